ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the decode stage.
- Owns the architectural fetch PC and issues one outstanding request at a time to the instruction memory.
- Buffers returned instructions in a 2-entry skid FIFO and presents {ins, pc, err} to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the buffer and squashing any in-flight response.

Parameters:
CPU_WIDTH, 64, PC/address width
INS_WIDTH, 32, instruction width
RESET_PC, 64'h8000_0000, PC fetched first after reset

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst  in  1  synchronous reset, active-high
i_redirect  in  1  redirect request from branch unit (single-cycle pulse or held)
i_redirect_pc  in  CPU_WIDTH  redirect target; bits[1:0] ignored (forced 0)
o_imem_req_valid  out  1  fetch request valid
i_imem_req_ready  in  1  memory accepts request
o_imem_addr  out  CPU_WIDTH  fetch address (= current PC)
i_imem_rsp_valid  in  1  response valid (always accepted)
i_imem_rsp_ins  in  INS_WIDTH  returned instruction
i_imem_rsp_err  in  1  access fault for this response
o_post_valid  out  1  instruction available to decode
i_post_ready  in  1  decode accepts
o_ifu_ins  out  INS_WIDTH  FIFO head instruction
o_ifu_pc  out  CPU_WIDTH  FIFO head PC
o_ifu_err  out  1  FIFO head fetch-fault flag

Behaviour:
- Reset (i_rst=1 at edge):
  - pc=RESET_PC, state=REQ, FIFO count=0, rptr=wptr=0.
  - FIFO storage cleared to 0.
  - o_post_valid=0; o_ifu_ins/pc/err=0; o_imem_req_valid=0 in the reset cycle.
  - o_imem_addr=RESET_PC.
  - Reset mid-transaction discards any outstanding request; a late response is ignored because state=REQ.
- State machine, 2-bit:
  - REQ: issue a request.
  - WAIT: one request outstanding.
  - DROP: outstanding request is stale.
- REQ:
  - o_imem_req_valid = (count + 0 < 2) & ~i_redirect & ~i_rst.
  - On req handshake: req_pc<=pc, pc<=pc+4 (wrap modulo 2^CPU_WIDTH), go to WAIT.
  - o_imem_addr is held stable while valid & ~ready.
- WAIT, on i_imem_rsp_valid:
  - Push {rsp_ins, req_pc, rsp_err} into the FIFO, go to REQ.
  - Space is guaranteed because a request is only issued when count<2 and the FIFO can only drain meanwhile.
- DROP: on i_imem_rsp_valid, discard the response and go to REQ.
- A response arriving in REQ is ignored (protocol error; must not corrupt state).
- Redirect has highest priority over push and pop in the same cycle:
  - pc <= {i_redirect_pc[CPU_WIDTH-1:2], 2'b00}.
  - FIFO flushed: count=0, pointers=0; a simultaneous pop is a no-op, and a simultaneous push is dropped.
  - State transitions on redirect:
    - REQ -> REQ; no request is issued that cycle.
    - WAIT with rsp_valid same cycle -> REQ; response dropped.
    - WAIT without rsp_valid -> DROP.
    - DROP with rsp_valid -> REQ.
    - DROP without rsp_valid -> DROP.
- Output FIFO (2 entries):
  - o_post_valid = count!=0; head = storage[rptr].
  - Pop when o_post_valid & i_post_ready; push and pop in the same cycle keep count unchanged.
  - Head outputs are stable while o_post_valid & ~i_post_ready.
- Latency:
  - Request issued in cycle N with a response in cycle N+k puts the entry at the FIFO head in cycle N+k+1.
  - With memory k=1 and decode always ready, steady-state throughput is one instruction per 2 cycles.
- Fetch faults: err passes through with the instruction. The block does not stop fetching; the trap is handled downstream.

Test Plan:
- Reset release, memory ready=1, rsp 1 cycle later with ins=0x00000013 -> first addr 0x80000000; o_post_valid=1 with pc=0x80000000, ins=0x13; next addr 0x80000004.
- Decode holds i_post_ready=0 for 10 cycles -> FIFO fills to 2 entries (pc 0x80000000, 0x80000004); no third request issued; head stable; after ready=1, entries drain in order and fetch resumes at 0x80000008.
- Redirect to 0x80001002 while in WAIT, response arrives 2 cycles later -> response discarded, FIFO empty, next request addr=0x80001000, first delivered pc=0x80001000.
- Redirect in the same cycle as rsp_valid and a decode pop with FIFO count=1 -> count becomes 0, response dropped, state REQ, next addr = redirect target.
- Response with i_imem_rsp_err=1 at pc 0x80000004 -> o_ifu_err=1 only for that entry; following fetch at 0x80000008 has err=0.
- Assert i_rst for 1 cycle while in WAIT, then a late response arrives -> response ignored, o_post_valid stays 0, fetch restarts at 0x80000000.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response and the decode handoff.
// The master modport is the fetch unit and the slave modport is its environment.
interface ifu_fetch_if #(
    parameter int unsigned CPU_WIDTH = 64,
    parameter int unsigned INS_WIDTH = 32
);
    logic                 o_imem_req_valid;
    logic                 i_imem_req_ready;
    logic [CPU_WIDTH-1:0] o_imem_addr;
    logic                 i_imem_rsp_valid;
    logic [INS_WIDTH-1:0] i_imem_rsp_ins;
    logic                 i_imem_rsp_err;
    logic                 o_post_valid;
    logic                 i_post_ready;
    logic [INS_WIDTH-1:0] o_ifu_ins;
    logic [CPU_WIDTH-1:0] o_ifu_pc;
    logic                 o_ifu_err;

    modport master (
        output o_imem_req_valid, o_imem_addr,
        input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_ins, i_imem_rsp_err,
        output o_post_valid, o_ifu_ins, o_ifu_pc, o_ifu_err,
        input  i_post_ready
    );

    modport slave (
        input  o_imem_req_valid, o_imem_addr,
        output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_ins, i_imem_rsp_err,
        input  o_post_valid, o_ifu_ins, o_ifu_pc, o_ifu_err,
        output i_post_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps one memory request in flight,
// and buffers responses in a 2-entry FIFO toward decode. Redirects flush and squash.
module ifu_fetch #(
    parameter int unsigned          CPU_WIDTH = 64,
    parameter int unsigned          INS_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = CPU_WIDTH'(64'h8000_0000)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_redirect,
    input  logic [CPU_WIDTH-1:0] i_redirect_pc,
    ifu_fetch_if.master          bus
);
    localparam int unsigned DEPTH = 2;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CPU_WIDTH-1:0] pc_q, pc_d;
    logic [CPU_WIDTH-1:0] req_pc_q, req_pc_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 rptr_q, rptr_d;
    logic                 wptr_q, wptr_d;

    logic [INS_WIDTH-1:0] fifo_ins_q [DEPTH];
    logic [CPU_WIDTH-1:0] fifo_pc_q  [DEPTH];
    logic [DEPTH-1:0]     fifo_err_q;

    logic req_valid_c;
    logic req_fire_c;
    logic push_c;
    logic pop_c;
    logic unused_redirect_lsb;

    // Low target bits are forced to zero, so they never reach the PC.
    assign unused_redirect_lsb = ^i_redirect_pc[1:0];

    // A request is only offered while the FIFO has room for its response.
    assign req_valid_c = (state_q == ST_REQ) && (cnt_q < 2'(DEPTH)) && !i_redirect && !i_rst;
    assign req_fire_c  = req_valid_c && bus.i_imem_req_ready;
    assign push_c      = (state_q == ST_WAIT) && bus.i_imem_rsp_valid && !i_redirect;
    assign pop_c       = (cnt_q != 2'd0) && bus.i_post_ready && !i_redirect;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_REQ;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            cnt_q    <= '0;
            rptr_q   <= 1'b0;
            wptr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            cnt_q    <= cnt_d;
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
        end
    end

    // Next-state: a redirect squashes any outstanding response via DROP.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        case (state_q)
            ST_REQ: begin
                if (req_fire_c) begin
                    state_d  = ST_WAIT;
                    req_pc_d = pc_q;
                    pc_d     = pc_q + CPU_WIDTH'(4);
                end
            end
            ST_WAIT: begin
                if (bus.i_imem_rsp_valid) begin
                    state_d = ST_REQ;
                end else if (i_redirect) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (bus.i_imem_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
        if (i_redirect) begin
            pc_d = {i_redirect_pc[CPU_WIDTH-1:2], 2'b00};
        end
    end

    // FIFO occupancy and pointers; a redirect empties the buffer outright.
    always_comb begin
        cnt_d  = cnt_q;
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        if (i_redirect) begin
            cnt_d  = 2'd0;
            rptr_d = 1'b0;
            wptr_d = 1'b0;
        end else begin
            if (push_c) begin
                wptr_d = ~wptr_q;
            end
            if (pop_c) begin
                rptr_d = ~rptr_q;
            end
            if (push_c && !pop_c) begin
                cnt_d = cnt_q + 2'd1;
            end else if (pop_c && !push_c) begin
                cnt_d = cnt_q - 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_ins_q[i] <= '0;
                fifo_pc_q[i]  <= '0;
            end
            fifo_err_q <= '0;
        end else if (push_c) begin
            fifo_ins_q[wptr_q] <= bus.i_imem_rsp_ins;
            fifo_pc_q[wptr_q]  <= req_pc_q;
            fifo_err_q[wptr_q] <= bus.i_imem_rsp_err;
        end
    end

    assign bus.o_imem_req_valid = req_valid_c;
    assign bus.o_imem_addr      = pc_q;
    assign bus.o_post_valid     = (cnt_q != 2'd0);
    assign bus.o_ifu_ins        = fifo_ins_q[rptr_q];
    assign bus.o_ifu_pc         = fifo_pc_q[rptr_q];
    assign bus.o_ifu_err        = fifo_err_q[rptr_q];

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: hand-driven memory and decode sides with
// hand-computed expectations for each step.
module tb_ifu_fetch;
    localparam int unsigned CPU_WIDTH = 64;
    localparam int unsigned INS_WIDTH = 32;
    localparam logic [63:0] RST_PC    = 64'h8000_0000;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 redirect;
    logic [CPU_WIDTH-1:0] redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;

    ifu_fetch_if #(.CPU_WIDTH(CPU_WIDTH), .INS_WIDTH(INS_WIDTH)) bus ();

    ifu_fetch #(
        .CPU_WIDTH(CPU_WIDTH),
        .INS_WIDTH(INS_WIDTH),
        .RESET_PC (RST_PC)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst                  = 1'b1;
        redirect             = 1'b0;
        redirect_pc          = '0;
        bus.i_imem_req_ready = 1'b0;
        bus.i_imem_rsp_valid = 1'b0;
        bus.i_imem_rsp_ins   = '0;
        bus.i_imem_rsp_err   = 1'b0;
        bus.i_post_ready     = 1'b0;
        tick();
        tick();
        rst                  = 1'b0;
        bus.i_imem_req_ready = 1'b1;
    endtask

    // Handshake one request, answer it next cycle, then settle for checks.
    task automatic fetch_one(input logic [31:0] ins, input logic err);
        tick();
        bus.i_imem_rsp_valid = 1'b1;
        bus.i_imem_rsp_ins   = ins;
        bus.i_imem_rsp_err   = err;
        tick();
        bus.i_imem_rsp_valid = 1'b0;
        bus.i_imem_rsp_err   = 1'b0;
        #1;
    endtask

    initial begin
        // Reset values, then first fetch with 1-cycle memory
        do_reset();
        rst = 1'b1;
        bus.i_imem_req_ready = 1'b0;
        tick();
        check_eq("rst_req_valid", 64'(bus.o_imem_req_valid), 64'd0);
        check_eq("rst_post_valid", 64'(bus.o_post_valid), 64'd0);
        check_eq("rst_ins", 64'(bus.o_ifu_ins), 64'd0);
        check_eq("rst_pc", bus.o_ifu_pc, 64'd0);
        check_eq("rst_err", 64'(bus.o_ifu_err), 64'd0);
        check_eq("rst_addr", bus.o_imem_addr, RST_PC);
        rst = 1'b0;
        bus.i_imem_req_ready = 1'b1;
        bus.i_post_ready     = 1'b1;
        #1;
        check_eq("t1_req_valid", 64'(bus.o_imem_req_valid), 64'd1);
        check_eq("t1_addr0", bus.o_imem_addr, 64'h8000_0000);
        tick();
        bus.i_imem_rsp_valid = 1'b1;
        bus.i_imem_rsp_ins   = 32'h0000_0013;
        #1;
        check_eq("t1_wait_no_req", 64'(bus.o_imem_req_valid), 64'd0);
        check_eq("t1_addr_next", bus.o_imem_addr, 64'h8000_0004);
        check_eq("t1_not_yet_valid", 64'(bus.o_post_valid), 64'd0);
        tick();
        bus.i_imem_rsp_valid = 1'b0;
        #1;
        check_eq("t1_post_valid", 64'(bus.o_post_valid), 64'd1);
        check_eq("t1_head_pc", bus.o_ifu_pc, 64'h8000_0000);
        check_eq("t1_head_ins", 64'(bus.o_ifu_ins), 64'h13);
        check_eq("t1_head_err", 64'(bus.o_ifu_err), 64'd0);
        check_eq("t1_req_again", 64'(bus.o_imem_req_valid), 64'd1);

        // Backpressure: FIFO fills to two, no third request, head stable
        do_reset();
        fetch_one(32'h0000_0013, 1'b0);
        fetch_one(32'h0010_0093, 1'b0);
        check_eq("t2_full_valid", 64'(bus.o_post_valid), 64'd1);
        check_eq("t2_full_no_req", 64'(bus.o_imem_req_valid), 64'd0);
        check_eq("t2_full_addr", bus.o_imem_addr, 64'h8000_0008);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("t2_hold_no_req", 64'(bus.o_imem_req_valid), 64'd0);
            check_eq("t2_hold_pc", bus.o_ifu_pc, 64'h8000_0000);
            check_eq("t2_hold_ins", 64'(bus.o_ifu_ins), 64'h13);
        end
        bus.i_post_ready = 1'b1;
        tick();
        check_eq("t2_drain1_pc", bus.o_ifu_pc, 64'h8000_0004);
        check_eq("t2_drain1_ins", 64'(bus.o_ifu_ins), 64'h0010_0093);
        check_eq("t2_resume_req", 64'(bus.o_imem_req_valid), 64'd1);
        check_eq("t2_resume_addr", bus.o_imem_addr, 64'h8000_0008);
        tick();
        check_eq("t2_drained", 64'(bus.o_post_valid), 64'd0);
        bus.i_imem_rsp_valid = 1'b1;
        bus.i_imem_rsp_ins   = 32'h0020_0113;
        tick();
        bus.i_imem_rsp_valid = 1'b0;
        #1;
        check_eq("t2_third_pc", bus.o_ifu_pc, 64'h8000_0008);
        check_eq("t2_third_ins", 64'(bus.o_ifu_ins), 64'h0020_0113);

        // Redirect while waiting; late response is squashed
        do_reset();
        bus.i_post_ready = 1'b1;
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'h8000_1002;
        #1;
        check_eq("t3_redir_no_req", 64'(bus.o_imem_req_valid), 64'd0);
        tick();
        redirect = 1'b0;
        #1;
        check_eq("t3_drop_no_req", 64'(bus.o_imem_req_valid), 64'd0);
        check_eq("t3_drop_addr", bus.o_imem_addr, 64'h8000_1000);
        tick();
        bus.i_imem_rsp_valid = 1'b1;
        bus.i_imem_rsp_ins   = 32'hdead_beef;
        tick();
        bus.i_imem_rsp_valid = 1'b0;
        #1;
        check_eq("t3_squashed", 64'(bus.o_post_valid), 64'd0);
        check_eq("t3_req_target", 64'(bus.o_imem_req_valid), 64'd1);
        check_eq("t3_addr_target", bus.o_imem_addr, 64'h8000_1000);
        fetch_one(32'h0030_0193, 1'b0);
        check_eq("t3_first_pc", bus.o_ifu_pc, 64'h8000_1000);
        check_eq("t3_first_ins", 64'(bus.o_ifu_ins), 64'h0030_0193);

        // Redirect + response + pop in one cycle with one entry buffered
        do_reset();
        fetch_one(32'h0000_0013, 1'b0);
        tick();
        check_eq("t4_pre_valid", 64'(bus.o_post_valid), 64'd1);
        bus.i_post_ready     = 1'b1;
        bus.i_imem_rsp_valid = 1'b1;
        bus.i_imem_rsp_ins   = 32'hbad0_0001;
        redirect             = 1'b1;
        redirect_pc          = 64'h8000_2000;
        tick();
        bus.i_imem_rsp_valid = 1'b0;
        redirect             = 1'b0;
        #1;
        check_eq("t4_flushed", 64'(bus.o_post_valid), 64'd0);
        check_eq("t4_req_valid", 64'(bus.o_imem_req_valid), 64'd1);
        check_eq("t4_addr", bus.o_imem_addr, 64'h8000_2000);
        fetch_one(32'h0040_0213, 1'b0);
        check_eq("t4_first_pc", bus.o_ifu_pc, 64'h8000_2000);

        // Fetch fault flag travels with its own entry only
        do_reset();
        bus.i_post_ready = 1'b1;
        fetch_one(32'h0000_0013, 1'b0);
        check_eq("t5_e0_err", 64'(bus.o_ifu_err), 64'd0);
        fetch_one(32'h0050_0293, 1'b1);
        check_eq("t5_e1_pc", bus.o_ifu_pc, 64'h8000_0004);
        check_eq("t5_e1_err", 64'(bus.o_ifu_err), 64'd1);
        fetch_one(32'h0060_0313, 1'b0);
        check_eq("t5_e2_pc", bus.o_ifu_pc, 64'h8000_0008);
        check_eq("t5_e2_err", 64'(bus.o_ifu_err), 64'd0);

        // Reset while waiting; the late response must be ignored
        do_reset();
        bus.i_post_ready = 1'b1;
        fetch_one(32'h0000_0013, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        check_eq("t6_rst_no_req", 64'(bus.o_imem_req_valid), 64'd0);
        tick();
        rst                  = 1'b0;
        bus.i_imem_req_ready = 1'b0;
        bus.i_imem_rsp_valid = 1'b1;
        bus.i_imem_rsp_ins   = 32'hbad0_0002;
        #1;
        check_eq("t6_restart_req", 64'(bus.o_imem_req_valid), 64'd1);
        check_eq("t6_restart_addr", bus.o_imem_addr, 64'h8000_0000);
        tick();
        bus.i_imem_rsp_valid = 1'b0;
        #1;
        check_eq("t6_late_ignored", 64'(bus.o_post_valid), 64'd0);
        check_eq("t6_addr_held", bus.o_imem_addr, 64'h8000_0000);
        bus.i_imem_req_ready = 1'b1;
        fetch_one(32'h0000_0017, 1'b0);
        check_eq("t6_first_pc", bus.o_ifu_pc, 64'h8000_0000);
        check_eq("t6_first_ins", 64'(bus.o_ifu_ins), 64'h17);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
